// File: rtl/fp16_pkg.sv
// Shared constants and the unpacked-operand type for the FP16 adder front end.
package fp16_pkg;

  localparam int unsigned EXP_W           = 5;
  localparam int unsigned FRAC_W          = 10;
  localparam int unsigned SIG_W           = 16;
  localparam int unsigned EXP_SUBNORM_EFF = 1;
  localparam int unsigned EXP_SPECIAL     = 31;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] eexp;
    logic [SIG_W-1:0] sig;
  } fp16_unpacked_t;

endpackage

// File: rtl/fp16_unpack.sv
// Combinational FP16 field split: hidden bit, effective exponent, left-justified significand.
module fp16_unpack
  import fp16_pkg::*;
(
  input  logic [15:0]    i_op,
  output fp16_unpacked_t o_unp
);

  logic [EXP_W-1:0]  w_exp;
  logic [FRAC_W-1:0] w_frac;
  logic              w_hidden;

  assign w_exp    = i_op[FRAC_W +: EXP_W];
  assign w_frac   = i_op[FRAC_W-1:0];
  assign w_hidden = |w_exp;

  // Subnormals share the scale of exponent 1 but have no hidden bit.
  assign o_unp.sign = i_op[15];
  assign o_unp.eexp = w_hidden ? w_exp : EXP_W'(EXP_SUBNORM_EFF);
  assign o_unp.sig  = {w_hidden, w_frac, {(SIG_W-FRAC_W-1){1'b0}}};

endmodule

// File: rtl/fp16_align_front.sv
// Two-stage FP16 unpack and magnitude-order stage feeding the alignment shifter.
// Optional FP16_ALIGN_STICKY_EN adds a sticky output for the bits the shifter discards.
module fp16_align_front
  import fp16_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      op_a,
  input  logic [15:0]      op_b,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SIG_W-1:0] big_sig,
  output logic [SIG_W-1:0] small_sig,
  output logic [EXP_W-1:0] diff,
  output logic [EXP_W-1:0] exp_big,
  output logic             sign_big,
  output logic             eff_sub,
`ifdef FP16_ALIGN_STICKY_EN
  output logic             sticky,
`endif
  output logic             swapped
);

  fp16_unpacked_t w_unp_a, w_unp_b;
  fp16_unpacked_t r_s1_a, r_s1_b;
  logic           r_s1_valid, r_s1_sub;
  logic           w_s1_load, w_s2_load;

  logic             r_s2_valid;
  logic [SIG_W-1:0] r_big_sig, r_small_sig;
  logic [EXP_W-1:0] r_diff, r_exp_big;
  logic             r_sign_big, r_eff_sub, r_swapped;

  fp16_unpack u_unpack_a (
    .i_op  (op_a),
    .o_unp (w_unp_a)
  );

  fp16_unpack u_unpack_b (
    .i_op  (op_b),
    .o_unp (w_unp_b)
  );

  assign w_s2_load = !r_s2_valid | out_ready;
  assign w_s1_load = !r_s1_valid | w_s2_load;
  assign in_ready  = w_s1_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_sub   <= 1'b0;
    end else if (w_s1_load) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_a   <= w_unp_a;
        r_s1_b   <= w_unp_b;
        r_s1_sub <= op_sub;
      end
    end
  end

  logic             w_swap;
  fp16_unpacked_t   w_big, w_small;
  logic [EXP_W-1:0] w_diff;

  assign w_swap  = (r_s1_b.eexp > r_s1_a.eexp) |
                   ((r_s1_b.eexp == r_s1_a.eexp) & (r_s1_b.sig > r_s1_a.sig));
  assign w_big   = w_swap ? r_s1_b : r_s1_a;
  assign w_small = w_swap ? r_s1_a : r_s1_b;
  assign w_diff  = w_big.eexp - w_small.eexp;

`ifdef FP16_ALIGN_STICKY_EN
  logic [SIG_W-1:0] w_mask;
  logic             w_sticky, r_sticky;

  // Mask of the bit positions a right shift by w_diff pushes out of the shifter.
  assign w_mask   = (w_diff >= EXP_W'(SIG_W)) ? '1 : ((SIG_W'(1) << w_diff) - SIG_W'(1));
  assign w_sticky = |(w_small.sig & w_mask);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid  <= 1'b0;
      r_big_sig   <= '0;
      r_small_sig <= '0;
      r_diff      <= '0;
      r_exp_big   <= '0;
      r_sign_big  <= 1'b0;
      r_eff_sub   <= 1'b0;
      r_swapped   <= 1'b0;
`ifdef FP16_ALIGN_STICKY_EN
      r_sticky    <= 1'b0;
`endif
    end else if (w_s2_load) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_big_sig   <= w_big.sig;
        r_small_sig <= w_small.sig;
        r_diff      <= w_diff;
        r_exp_big   <= w_big.eexp;
        r_sign_big  <= w_swap ? (r_s1_b.sign ^ r_s1_sub) : r_s1_a.sign;
        r_eff_sub   <= r_s1_a.sign ^ r_s1_b.sign ^ r_s1_sub;
        r_swapped   <= w_swap;
`ifdef FP16_ALIGN_STICKY_EN
        r_sticky    <= w_sticky;
`endif
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign big_sig   = r_big_sig;
  assign small_sig = r_small_sig;
  assign diff      = r_diff;
  assign exp_big   = r_exp_big;
  assign sign_big  = r_sign_big;
  assign eff_sub   = r_eff_sub;
  assign swapped   = r_swapped;
`ifdef FP16_ALIGN_STICKY_EN
  assign sticky    = r_sticky;
`endif

endmodule

// File: tb/tb_fp16_align_front.sv
// Directed self-checking bench for fp16_align_front.
module tb_fp16_align_front;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] op_a, op_b;
  logic        op_sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] big_sig, small_sig;
  logic [4:0]  diff, exp_big;
  logic        sign_big, eff_sub, swapped;
`ifdef FP16_ALIGN_STICKY_EN
  logic        sticky;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fp16_align_front dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_sub    (op_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .big_sig   (big_sig),
    .small_sig (small_sig),
    .diff      (diff),
    .exp_big   (exp_big),
    .sign_big  (sign_big),
    .eff_sub   (eff_sub),
`ifdef FP16_ALIGN_STICKY_EN
    .sticky    (sticky),
`endif
    .swapped   (swapped)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single transaction with out_ready high; result expected after the second edge.
  task automatic run_pair(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic sub, input logic [15:0] e_big, input logic [15:0] e_small,
                          input logic [4:0] e_diff, input logic [4:0] e_exp, input logic e_sign,
                          input logic e_eff, input logic e_swp, input logic e_sticky);
    op_a = a; op_b = b; op_sub = sub; in_valid = 1'b1; out_ready = 1'b1;
    check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check({tag, ".early_valid"}, 32'(out_valid), 32'd0);
    tick();
    check({tag, ".out_valid"}, 32'(out_valid), 32'd1);
    check({tag, ".big_sig"},   32'(big_sig),   32'(e_big));
    check({tag, ".small_sig"}, 32'(small_sig), 32'(e_small));
    check({tag, ".diff"},      32'(diff),      32'(e_diff));
    check({tag, ".exp_big"},   32'(exp_big),   32'(e_exp));
    check({tag, ".sign_big"},  32'(sign_big),  32'(e_sign));
    check({tag, ".eff_sub"},   32'(eff_sub),   32'(e_eff));
    check({tag, ".swapped"},   32'(swapped),   32'(e_swp));
`ifdef FP16_ALIGN_STICKY_EN
    check({tag, ".sticky"},    32'(sticky),    32'(e_sticky));
`else
    if (e_sticky === 1'bx) check({tag, ".sticky_arg"}, 32'(e_sticky), 32'd0);
`endif
    tick();
    check({tag, ".drained"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op_a = '0; op_b = '0; op_sub = 1'b0;
    #3;
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.big_sig",   32'(big_sig),   32'd0);
    check("rst.diff",      32'(diff),      32'd0);
    check("rst.swapped",   32'(swapped),   32'd0);
    #10 rst_n = 1'b1;
    tick();
    check("rst.in_ready", 32'(in_ready), 32'd1);

    //        tag    a        b        sub   big      small    diff  exp   sgn   eff   swp   stk
    run_pair("t1", 16'h3C00, 16'h3800, 1'b0, 16'h8000, 16'h8000, 5'd1, 5'd15, 1'b0, 1'b0, 1'b0, 1'b0);
    run_pair("t2", 16'h3800, 16'hBC00, 1'b0, 16'h8000, 16'h8000, 5'd1, 5'd15, 1'b1, 1'b1, 1'b1, 1'b0);
    run_pair("t3", 16'h3C00, 16'h3E00, 1'b1, 16'hC000, 16'h8000, 5'd0, 5'd15, 1'b1, 1'b1, 1'b1, 1'b0);
    run_pair("t4", 16'h3C00, 16'h0001, 1'b0, 16'h8000, 16'h0020, 5'd14, 5'd15, 1'b0, 1'b0, 1'b0, 1'b1);
    run_pair("t5", 16'h3C00, 16'h0400, 1'b0, 16'h8000, 16'h8000, 5'd14, 5'd15, 1'b0, 1'b0, 1'b0, 1'b0);
    run_pair("eq", 16'h4000, 16'hC000, 1'b0, 16'h8000, 16'h8000, 5'd0, 5'd16, 1'b0, 1'b1, 1'b0, 1'b0);
    run_pair("inf", 16'h7C00, 16'h3C00, 1'b0, 16'h8000, 16'h8000, 5'd16, 5'd31, 1'b0, 1'b0, 1'b0, 1'b1);
    run_pair("max", 16'h7BFF, 16'h0001, 1'b1, 16'hFFE0, 16'h0020, 5'd29, 5'd30, 1'b0, 1'b1, 1'b0, 1'b1);
    run_pair("sub", 16'h0001, 16'h0002, 1'b0, 16'h0040, 16'h0020, 5'd0, 5'd1, 1'b0, 1'b0, 1'b1, 1'b0);

    // Backpressure: three pairs with diffs 1, 2, 3 tag their order.
    out_ready = 1'b0; op_sub = 1'b0; op_b = 16'h3800;
    op_a = 16'h3C00; in_valid = 1'b1;
    tick();
    check("bp.ready1", 32'(in_ready), 32'd1);
    op_a = 16'h4000;
    tick();
    op_a = 16'h4400;
    check("bp.full_ready", 32'(in_ready), 32'd0);
    check("bp.valid", 32'(out_valid), 32'd1);
    tick();
    tick();
    check("bp.still_full", 32'(in_ready), 32'd0);
    check("bp.hold_diff", 32'(diff), 32'd1);
    out_ready = 1'b1;
    #1;
    check("bp.release_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check("bp.r2_valid", 32'(out_valid), 32'd1);
    check("bp.r2_diff",  32'(diff),      32'd2);
    tick();
    check("bp.r3_valid", 32'(out_valid), 32'd1);
    check("bp.r3_diff",  32'(diff),      32'd3);
    check("bp.r3_exp",   32'(exp_big),   32'd17);
    tick();
    check("bp.empty", 32'(out_valid), 32'd0);

    // Reset while both stages hold data.
    out_ready = 1'b0; op_a = 16'h4400; op_b = 16'h3800; in_valid = 1'b1;
    tick();
    tick();
    in_valid = 1'b0;
    check("rs.full", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check("rs.out_valid", 32'(out_valid), 32'd0);
    check("rs.diff",      32'(diff),      32'd0);
    #3 rst_n = 1'b1;
    #1;
    check("rs.in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    tick();
    tick();
    tick();
    check("rs.no_stale", 32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
